// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetches 32-bit instructions as four byte reads, assembles them
//            little-endian and presents them over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rd_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  misaligned_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [1:0]            r_byte_cnt;
  logic [1:0]            r_cap_idx;
  logic                  r_cap_valid;
  logic [31:0]           r_instr_data;
  logic                  w_handshake;
  logic                  w_redirect_aligned;

  assign w_issue_addr       = r_pc + ADDR_WIDTH'(r_byte_cnt);
  assign w_handshake        = (r_state == S_HOLD) && instr_ready;
  assign w_redirect_aligned = (redirect_addr[1:0] == 2'b00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (redirect_valid) begin
      w_next_state = w_redirect_aligned ? S_ISSUE : S_ERROR;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_ISSUE;
        S_ISSUE: w_next_state = (r_byte_cnt == 2'd3) ? S_DRAIN : S_ISSUE;
        S_DRAIN: w_next_state = S_HOLD;
        S_HOLD:  w_next_state = w_handshake ? S_ISSUE : S_HOLD;
        S_ERROR: w_next_state = S_ERROR;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd_en      = 1'b0;
    mem_addr       = r_last_addr;
    instr_valid    = 1'b0;
    misaligned_err = 1'b0;
    case (r_state)
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = w_issue_addr;
      end
      S_HOLD:  instr_valid    = 1'b1;
      S_ERROR: misaligned_err = 1'b1;
      default: ;
    endcase
  end

  // Each issued read returns one cycle later; r_cap_* tracks which byte lane
  // the returning byte belongs to so a redirect can drop it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_byte_cnt   <= 2'd0;
      r_cap_valid  <= 1'b0;
      r_cap_idx    <= 2'd0;
      r_instr_data <= 32'd0;
      r_instr_pc   <= RESET_PC;
      r_last_addr  <= RESET_PC;
    end else begin
      if (r_state == S_ISSUE) r_last_addr <= w_issue_addr;
      if (redirect_valid) begin
        r_pc        <= redirect_addr;
        r_byte_cnt  <= 2'd0;
        r_cap_valid <= 1'b0;
      end else begin
        if (r_cap_valid) r_instr_data[{r_cap_idx, 3'b000} +: 8] <= mem_rd_data;
        r_cap_valid <= (r_state == S_ISSUE);
        r_cap_idx   <= r_byte_cnt;
        case (r_state)
          S_ISSUE: r_byte_cnt <= r_byte_cnt + 2'd1;
          S_DRAIN: r_instr_pc <= r_pc;
          S_HOLD: begin
            if (w_handshake) begin
              r_pc       <= r_pc + ADDR_WIDTH'(3'd4);
              r_byte_cnt <= 2'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign instr_data = r_instr_data;
  assign instr_pc   = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit against a cycle-count
//            reference model of fetch progress.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rd_data = 8'h00;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        misaligned_err;

  int total = 0;
  int bad   = 0;

  // Reference model: m_age counts edges since the current fetch started
  // (-1 before the first edge after reset, saturating at 5 once delivered).
  logic [31:0] m_pc;
  logic [31:0] m_last;
  logic        m_err;
  int          m_age;

  instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .misaligned_err (misaligned_err)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h10;
      32'd1:   return 8'h03;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] p);
    return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
  endfunction

  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem_byte(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_last = 32'h0;
    m_err  = 1'b0;
    m_age  = -1;
  endtask

  task automatic check_outputs();
    if (m_age < 0) begin
      check("idle_rd_en", {31'd0, mem_rd_en}, 32'd0);
      check("idle_addr", mem_addr, m_last);
      check("idle_valid", {31'd0, instr_valid}, 32'd0);
      check("idle_data", instr_data, 32'd0);
      check("idle_pc", instr_pc, 32'd0);
      check("idle_err", {31'd0, misaligned_err}, 32'd0);
    end else if (m_err) begin
      check("err_flag", {31'd0, misaligned_err}, 32'd1);
      check("err_rd_en", {31'd0, mem_rd_en}, 32'd0);
      check("err_valid", {31'd0, instr_valid}, 32'd0);
      check("err_addr", mem_addr, m_last);
    end else begin
      check("err_clear", {31'd0, misaligned_err}, 32'd0);
      if (m_age < 4) begin
        check("rd_en", {31'd0, mem_rd_en}, 32'd1);
        check("rd_addr", mem_addr, m_pc + 32'(m_age));
        check("valid_low", {31'd0, instr_valid}, 32'd0);
      end else begin
        check("no_rd", {31'd0, mem_rd_en}, 32'd0);
        check("hold_addr", mem_addr, m_last);
        check("valid", {31'd0, instr_valid}, (m_age >= 5) ? 32'd1 : 32'd0);
        if (m_age >= 5) begin
          check("instr_pc", instr_pc, m_pc);
          check("instr_data", instr_data, mem_word(m_pc));
          if (m_pc == 32'h0) check("word0", instr_data, 32'h0010_0310);
        end
      end
    end
  endtask

  task automatic model_advance(input logic rdy, input logic redir, input logic [31:0] raddr);
    if (m_age >= 0 && m_age < 4 && !m_err) m_last = m_pc + 32'(m_age);
    if (redir) begin
      m_pc  = raddr;
      m_age = 0;
      m_err = (raddr[1:0] != 2'b00);
    end else if (m_age < 0) begin
      m_age = 0;
    end else if (!m_err) begin
      if (m_age >= 5 && rdy) begin
        m_pc  = m_pc + 32'd4;
        m_age = 0;
      end else if (m_age < 5) begin
        m_age++;
      end
    end
  endtask

  // Called at a falling edge: check, drive the inputs for the next rising
  // edge, advance the model, then move to the next falling edge.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] raddr);
    check_outputs();
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
    model_advance(rdy, redir, raddr);
    @(negedge clock);
  endtask

  initial begin
    logic        rdy;
    logic        redir;
    logic [31:0] raddr;

    reset          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Word at 0 with ready high, then the next word held for ten cycles.
    repeat (7) tick(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10 && m_age < 5; i++) tick(1'b0, 1'b0, 32'h0);
    repeat (10) tick(1'b0, 1'b0, 32'h0);
    repeat (3) tick(1'b1, 1'b0, 32'h0);

    // Asynchronous reset asserted between edges while holding a word.
    for (int i = 0; i < 10 && m_age < 5; i++) tick(1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_data", instr_data, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_err", {31'd0, misaligned_err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Redirect to 0x8 while byte 2 of pc=0 is being issued.
    for (int i = 0; i < 10 && m_age != 2; i++) tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h8);
    repeat (8) tick(1'b1, 1'b0, 32'h0);

    // Misaligned redirect, then recovery with an aligned one.
    tick(1'b1, 1'b1, 32'h6);
    repeat (4) tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'hC);
    repeat (8) tick(1'b1, 1'b0, 32'h0);

    // Wrap at the top of the address space.
    tick(1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (10) tick(1'b1, 1'b0, 32'h0);

    // Randomized traffic: ready back-pressure and sporadic redirects.
    for (int i = 0; i < 600; i++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       raddr = $urandom & 32'hFFFF_FFFC;
        1:       raddr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        2:       raddr = 32'($urandom_range(0, 63) * 4);
        default: raddr = $urandom;
      endcase
      tick(rdy, redir, raddr);
    end
    tick(1'b1, 1'b1, 32'h20);
    repeat (8) tick(1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
